// File: rtl/pwm_ramp_ctrl.sv
// Duty-ramp sequencer in front of a pwm instance: slews pwm_ratio toward the target through an update/done handshake.
// Optional handshake-timeout fault is built when PWM_RAMP_TIMEOUT_EN is defined.
module pwm_ramp_ctrl #(
    parameter int unsigned INT_W        = 16,
    parameter int unsigned DONE_TIMEOUT = 512
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [7:0]       target_duty,
    input  logic             target_valid,
    input  logic [7:0]       ramp_step,
    input  logic [INT_W-1:0] ramp_interval,
    input  logic             brake,
    input  logic             fault_clr,
    input  logic             pwm_done,
    output logic             pwm_enable,
    output logic [7:0]       pwm_ratio,
    output logic             pwm_update,
    output logic [7:0]       current_duty,
    output logic             busy,
    output logic             at_target,
    output logic             fault
);

    localparam logic [2:0] ST_DISABLED  = 3'd0;
    localparam logic [2:0] ST_HOLD      = 3'd1;
    localparam logic [2:0] ST_WAIT_INT  = 3'd2;
    localparam logic [2:0] ST_DONE_WAIT = 3'd3;
`ifdef PWM_RAMP_TIMEOUT_EN
    localparam logic [2:0] ST_FAULT     = 3'd4;
    localparam int unsigned TO_W = (DONE_TIMEOUT > 2) ? $clog2(DONE_TIMEOUT) : 1;
`endif

    logic [2:0]       state, state_nxt;
    logic [7:0]       target_reg, target_nxt;
    logic [7:0]       cur_nxt, ratio_nxt;
    logic             en_nxt, upd_nxt, busy_nxt, at_target_nxt;
    logic [INT_W-1:0] int_cnt, int_cnt_nxt;
    logic             brake_pend, brake_nxt;
    logic             accept_c;

    logic [7:0] eff_tgt;
    logic [7:0] step_eff;
    logic [8:0] diff_up, diff_dn;
    logic [7:0] step_next;

`ifdef PWM_RAMP_TIMEOUT_EN
    logic            fault_nxt;
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    assign accept_c = (state != ST_FAULT);
`else
    logic unused_cfg;
    assign accept_c   = 1'b1;
    assign fault      = 1'b0;
    assign unused_cfg = &{1'b0, fault_clr, 1'(DONE_TIMEOUT % 2)};
`endif

    // Bounded step toward the effective target; 9-bit differences so nothing wraps.
    assign eff_tgt  = enable ? target_reg : 8'd0;
    assign step_eff = (ramp_step == 8'd0) ? 8'd1 : ramp_step;
    assign diff_up  = {1'b0, eff_tgt} - {1'b0, current_duty};
    assign diff_dn  = {1'b0, current_duty} - {1'b0, eff_tgt};

    always_comb begin
        step_next = current_duty;
        if (eff_tgt > current_duty)
            step_next = (diff_up <= {1'b0, step_eff}) ? eff_tgt : current_duty + step_eff;
        else if (eff_tgt < current_duty)
            step_next = (diff_dn <= {1'b0, step_eff}) ? eff_tgt : current_duty - step_eff;
    end

    always_comb begin
        state_nxt   = state;
        target_nxt  = target_reg;
        cur_nxt     = current_duty;
        ratio_nxt   = pwm_ratio;
        en_nxt      = pwm_enable;
        upd_nxt     = pwm_update;
        int_cnt_nxt = int_cnt;
        brake_nxt   = brake_pend;
`ifdef PWM_RAMP_TIMEOUT_EN
        fault_nxt   = fault;
        to_cnt_nxt  = to_cnt;
`endif

        case (state)
            ST_DISABLED: begin
                en_nxt  = 1'b0;
                upd_nxt = 1'b0;
                if (enable) begin
                    state_nxt = ST_HOLD;
                    en_nxt    = 1'b1;
                end
            end
            ST_HOLD: begin
                brake_nxt = 1'b0;
                if (brake_pend && current_duty != 8'd0) begin
                    ratio_nxt = 8'd0;
                    upd_nxt   = 1'b1;
                    state_nxt = ST_DONE_WAIT;
                end else if (eff_tgt != current_duty) begin
                    int_cnt_nxt = ramp_interval;
                    state_nxt   = ST_WAIT_INT;
                end else if (!enable && current_duty == 8'd0) begin
                    en_nxt    = 1'b0;
                    state_nxt = ST_DISABLED;
                end
            end
            ST_WAIT_INT: begin
                if (brake_pend) begin
                    brake_nxt = 1'b0;
                    if (current_duty != 8'd0) begin
                        ratio_nxt = 8'd0;
                        upd_nxt   = 1'b1;
                        state_nxt = ST_DONE_WAIT;
                    end else begin
                        state_nxt = ST_HOLD;
                    end
                end else if (int_cnt == '0) begin
                    // Target may have moved back onto current_duty while waiting.
                    if (step_next == current_duty) begin
                        state_nxt = ST_HOLD;
                    end else begin
                        ratio_nxt = step_next;
                        upd_nxt   = 1'b1;
                        state_nxt = ST_DONE_WAIT;
                    end
                end else begin
                    int_cnt_nxt = int_cnt - INT_W'(1);
                end
            end
            ST_DONE_WAIT: begin
                if (pwm_done) begin
                    upd_nxt = 1'b0;
                    cur_nxt = pwm_ratio;
`ifdef PWM_RAMP_TIMEOUT_EN
                    to_cnt_nxt = '0;
`endif
                    if (brake_pend && pwm_ratio != 8'd0) begin
                        state_nxt = ST_WAIT_INT;
                    end else if (pwm_ratio == eff_tgt) begin
                        brake_nxt = 1'b0;
                        state_nxt = ST_HOLD;
                    end else begin
                        int_cnt_nxt = ramp_interval;
                        state_nxt   = ST_WAIT_INT;
                    end
                end
`ifdef PWM_RAMP_TIMEOUT_EN
                else if (to_cnt == TO_W'(DONE_TIMEOUT - 1)) begin
                    fault_nxt  = 1'b1;
                    en_nxt     = 1'b0;
                    upd_nxt    = 1'b0;
                    brake_nxt  = 1'b0;
                    to_cnt_nxt = '0;
                    state_nxt  = ST_FAULT;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
`endif
            end
`ifdef PWM_RAMP_TIMEOUT_EN
            ST_FAULT: begin
                fault_nxt = 1'b1;
                en_nxt    = 1'b0;
                upd_nxt   = 1'b0;
                brake_nxt = 1'b0;
                if (fault_clr) begin
                    fault_nxt = 1'b0;
                    cur_nxt   = 8'd0;
                    ratio_nxt = 8'd0;
                    state_nxt = ST_DISABLED;
                end
            end
`endif
            default: state_nxt = ST_DISABLED;
        endcase

        // Target/brake capture last so a fresh brake pulse is never lost to a same-cycle clear.
        if (accept_c) begin
            if (target_valid)
                target_nxt = target_duty;
            if (brake) begin
                target_nxt = 8'd0;
                brake_nxt  = 1'b1;
            end
        end

        busy_nxt      = (state_nxt == ST_WAIT_INT) || (state_nxt == ST_DONE_WAIT);
        at_target_nxt = (state_nxt == ST_HOLD) && (cur_nxt == (enable ? target_nxt : 8'd0));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_DISABLED;
            target_reg   <= 8'd0;
            current_duty <= 8'd0;
            pwm_ratio    <= 8'd0;
            pwm_enable   <= 1'b0;
            pwm_update   <= 1'b0;
            busy         <= 1'b0;
            at_target    <= 1'b0;
            int_cnt      <= '0;
            brake_pend   <= 1'b0;
        end else begin
            state        <= state_nxt;
            target_reg   <= target_nxt;
            current_duty <= cur_nxt;
            pwm_ratio    <= ratio_nxt;
            pwm_enable   <= en_nxt;
            pwm_update   <= upd_nxt;
            busy         <= busy_nxt;
            at_target    <= at_target_nxt;
            int_cnt      <= int_cnt_nxt;
            brake_pend   <= brake_nxt;
        end
    end

`ifdef PWM_RAMP_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fault  <= 1'b0;
            to_cnt <= '0;
        end else begin
            fault  <= fault_nxt;
            to_cnt <= to_cnt_nxt;
        end
    end
`endif

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Sequencer sitting in front of one pwm instance; drives its pwm_enable, pwm_ratio and pwm_update, and consumes pwm_done.
- Software/motor logic supplies a target duty; the block slews the applied duty toward it in bounded steps at a programmable interval.
- Each step completes the update/done handshake before the next step is issued. Handles enable ramp-down, brake and a handshake-timeout fault.

Parameters:
- INT_W, 16, width of ramp_interval and interval counter.
- DONE_TIMEOUT, 512, cycles allowed in DONE_WAIT before fault (must exceed one 256-cycle PWM period).

Ports:
- clock  in  1  main clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  level; run request
- target_duty  in  8  requested duty (of 255)
- target_valid  in  1  pulse; latch target_duty
- ramp_step  in  8  max duty change per update; 0 treated as 1
- ramp_interval  in  INT_W  idle cycles between updates
- brake  in  1  pulse; jump directly to duty 0
- fault_clr  in  1  pulse; leave FAULT
- pwm_done  in  1  from pwm; update applied
- pwm_enable  out  1  to pwm
- pwm_ratio  out  8  to pwm
- pwm_update  out  1  to pwm; level request
- current_duty  out  8  last acknowledged duty
- busy  out  1  high in WAIT_INT/DONE_WAIT
- at_target  out  1  high in HOLD when current_duty == effective target
- fault  out  1  handshake timeout latched

Behaviour:
- Reset (async, including mid-operation): state DISABLED; target_reg, current_duty, pwm_ratio = 0; pwm_enable, pwm_update, busy, at_target, fault = 0; counters = 0.
- target_valid: target_reg <= target_duty in every state except FAULT; applies from the next step decision.
- Effective target = target_reg when enable=1, otherwise 0.
- DISABLED: pwm_enable=0. On enable=1, go to HOLD with pwm_enable=1 on the same edge.
- HOLD: if effective target != current_duty, load interval counter with ramp_interval and go to WAIT_INT. If enable=0 and current_duty==0, go to DISABLED.
- WAIT_INT: counter decrements once per cycle. When the counter is 0, compute next; pwm_ratio <= next, pwm_update <= 1, go to DONE_WAIT. With ramp_interval=0, the update is issued the cycle after entry.
- Step arithmetic (9-bit, no wrap): up: next = (tgt - cur <= step) ? tgt : cur + step; down: next = (cur - tgt <= step) ? tgt : cur - step. Never overshoots.
- DONE_WAIT: pwm_update stays high and pwm_ratio is stable. On the first cycle pwm_done is sampled 1: pwm_update <= 0, current_duty <= pwm_ratio, timeout counter cleared. Next state is HOLD if the new duty equals the effective target, otherwise WAIT_INT (interval reloaded).
- Retarget mid-ramp: an in-flight handshake always completes; the new target is used at the next step decision.
- brake: flag latched until serviced. From HOLD/WAIT_INT, the next update is pwm_ratio=0 immediately, bypassing interval and step. In DONE_WAIT, the current handshake finishes first, then the 0 update is issued. brake also clears target_reg to 0.
- Timeout: counter runs only in DONE_WAIT. When it reaches DONE_TIMEOUT, go to FAULT.
- FAULT: fault=1, pwm_enable=0, pwm_update=0; target_valid and brake ignored. On fault_clr, go to DISABLED with current_duty=0, pwm_ratio=0 and fault cleared. fault_clr and a fault in the same cycle: fault wins.
- busy = state in {WAIT_INT, DONE_WAIT}.

Optional Feature:
- PWM_RAMP_TIMEOUT_EN defined: timeout counter, FAULT state and fault_clr behave as specified above.
- Undefined: DONE_WAIT waits indefinitely; fault tied to 0; fault_clr ignored; no timeout counter logic is synthesized.

Test Plan:
- enable=1, target 100, step 25, interval 10, pwm model acking each update -> pwm_ratio sequence 25,50,75,100; ≥11 cycles between updates; at_target=1 after the final ack.
- target 100, step 30 -> 30,60,90,100 (no overshoot); then target_valid 40 -> 70,40.
- From duty 100, step 40, drop enable -> 60,20,0, then pwm_enable=0 and state DISABLED.
- Duty 200, brake pulse during WAIT_INT -> single update to 0 with no interval wait; at_target=1 with target_reg=0. Brake during DONE_WAIT -> current ack completes first, then update to 0.
- PWM_RAMP_TIMEOUT_EN defined, pwm_done held 0 -> fault=1 after 512 cycles in DONE_WAIT, pwm_enable=0; fault_clr -> DISABLED with current_duty=0. Same stimulus with the macro undefined -> no fault; pwm_update stays high.
- reset_n asserted mid-DONE_WAIT -> all outputs 0 immediately (asynchronously); after release, block is in DISABLED.
